tm1638_display_ctrl: RTL and testbench



---
 rtl/tm1638_pkg.sv | 20 ++
 rtl/tm1638_display_ctrl_seg7.sv | 24 ++
 rtl/tm1638_display_ctrl.sv | 176 +++++++++++++++++
 tb/tb_tm1638_display_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_pkg.sv
// Shared constants and FSM encoding for the TM1638 display sequencer.
package tm1638_pkg;

  localparam logic [7:0] CMD_DATA_WRITE = 8'h40;
  localparam logic [7:0] CMD_ADDR0      = 8'hC0;
  localparam logic [7:0] CMD_DISP_ON    = 8'h88;
  localparam logic [7:0] CMD_DISP_OFF   = 8'h80;

  localparam int NUM_DIGITS  = 8;
  localparam int FRAME_BYTES = 16;

  typedef enum logic [2:0] {
    IDLE,
    STB_LEAD,
    BIT_LOW,
    BIT_HIGH,
    STB_GAP
  } state_t;

endpackage

// File: rtl/tm1638_display_ctrl_seg7.sv
// BCD to 7-segment translator; code order a..g,dp with a in bit 7.
// Non-decimal nibbles light only the decimal point as an error mark.
module tm1638_display_ctrl_seg7 (
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = 8'hFC;
      4'd1:    seg = 8'h60;
      4'd2:    seg = 8'hDA;
      4'd3:    seg = 8'hF2;
      4'd4:    seg = 8'h66;
      4'd5:    seg = 8'hB6;
      4'd6:    seg = 8'hBE;
      4'd7:    seg = 8'hE0;
      4'd8:    seg = 8'hFE;
      4'd9:    seg = 8'hF6;
      default: seg = 8'h01;
    endcase
  end

endmodule

// File: rtl/tm1638_display_ctrl.sv
// Write-only TM1638 refresh sequencer: snapshots digits/LEDs/brightness on start
// and serialises the three-segment command frame on STB/CLK/DIO.
module tm1638_display_ctrl
  import tm1638_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] digits,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  leds,
  input  logic [2:0]  brightness,
  input  logic        display_on,
  output logic        busy,
  output logic        done,
  output logic        tm_stb,
  output logic        tm_clk,
  output logic        tm_dio
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t           state, state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [4:0]       byte_idx;
  logic [1:0]       seg_idx;

  logic [31:0] digits_q;
  logic [7:0]  dp_q;
  logic [7:0]  leds_q;
  logic [7:0]  cmd_disp_q;

  logic       tick;
  logic       last_bit;
  logic       last_byte;
  logic       gap_end;
  logic [2:0] digit_sel;
  logic [2:0] led_sel;
  logic [3:0] nibble;
  logic [7:0] seg_code;
  logic [7:0] tx_byte;
  logic       tx_msb_first;
  logic       tx_bit;

  assign tick      = (div_cnt == DIV_LAST);
  assign last_bit  = (bit_cnt == 3'd7);
  assign last_byte = (byte_idx == ((seg_idx == 2'd1) ? 5'(FRAME_BYTES) : 5'd0));
  // In STB_GAP the bit counter counts D-long phases: 0 = STB-low trail, 1..2 = STB-high gap.
  assign gap_end   = (bit_cnt == 3'd2);

  // Odd byte indices carry digit byte_idx/2; even ones (>0) carry LED byte_idx/2-1.
  assign digit_sel = byte_idx[3:1];
  assign led_sel   = byte_idx[3:1] - 3'd1;
  assign nibble    = digits_q[{~digit_sel, 2'b00} +: 4];

  tm1638_display_ctrl_seg7 u_seg7 (
    .bcd (nibble),
    .seg (seg_code)
  );

  // State register and sequencing counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      seg_idx  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      state <= state_next;
      if (state == IDLE) begin
        div_cnt  <= '0;
        bit_cnt  <= '0;
        byte_idx <= '0;
        seg_idx  <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          case (state)
            BIT_HIGH: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit && !last_byte) byte_idx <= byte_idx + 5'd1;
            end
            STB_GAP: begin
              if (gap_end) begin
                bit_cnt  <= '0;
                byte_idx <= '0;
                seg_idx  <= seg_idx + 2'd1;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // NOTE: the snapshot registers are pure data loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      digits_q   <= digits;
      dp_q       <= dp_mask;
      leds_q     <= leds;
      cmd_disp_q <= display_on ? (CMD_DISP_ON | {5'b0, brightness}) : CMD_DISP_OFF;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = STB_LEAD;
      STB_LEAD: if (tick) state_next = BIT_LOW;
      BIT_LOW:  if (tick) state_next = BIT_HIGH;
      BIT_HIGH: if (tick) state_next = (last_bit && last_byte) ? STB_GAP : BIT_LOW;
      STB_GAP:  if (tick && gap_end) state_next = (seg_idx == 2'd2) ? IDLE : STB_LEAD;
      default:  state_next = IDLE;
    endcase
  end

  // Byte selection; segment bytes go out seg[7] first so segment a lands in TM1638 bit0.
  always_comb begin
    tx_byte      = 8'h00;
    tx_msb_first = 1'b0;
    case (seg_idx)
      2'd0: tx_byte = CMD_DATA_WRITE;
      2'd1: begin
        if (byte_idx == 5'd0) begin
          tx_byte = CMD_ADDR0;
        end else if (byte_idx[0]) begin
          tx_byte      = seg_code | {7'b0, dp_q[~digit_sel]};
          tx_msb_first = 1'b1;
        end else begin
          tx_byte = {7'b0, leds_q[~led_sel]};
        end
      end
      2'd2: tx_byte = cmd_disp_q;
      default: ;
    endcase
    tx_bit = tx_msb_first ? tx_byte[~bit_cnt] : tx_byte[bit_cnt];
  end

  always_comb begin
    tm_stb = 1'b1;
    tm_clk = 1'b1;
    tm_dio = 1'b1;
    busy   = 1'b1;
    done   = 1'b0;
    case (state)
      IDLE:     busy   = 1'b0;
      STB_LEAD: tm_stb = 1'b0;
      BIT_LOW: begin
        tm_stb = 1'b0;
        tm_clk = 1'b0;
        tm_dio = tx_bit;
      end
      BIT_HIGH: begin
        tm_stb = 1'b0;
        tm_dio = tx_bit;
      end
      STB_GAP: begin
        tm_stb = (bit_cnt != 3'd0);
        done   = tick && gap_end && (seg_idx == 2'd2);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tm1638_display_ctrl.sv
// Self-checking bench: decodes the serial pins of two sequencer instances
// (CLK_DIV=2 and CLK_DIV=5) and compares frames and timing to a reference model.
module tb_tm1638_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start2 = 1'b0;
  logic        start5 = 1'b0;
  logic [31:0] digits = '0;
  logic [7:0]  dp_mask = '0;
  logic [7:0]  leds = '0;
  logic [2:0]  brightness = '0;
  logic        display_on = 1'b0;

  logic busy2, done2, stb2, sclk2, dio2;
  logic busy5, done5, stb5, sclk5, dio5;

  tm1638_display_ctrl #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .digits(digits), .dp_mask(dp_mask),
    .leds(leds), .brightness(brightness), .display_on(display_on),
    .busy(busy2), .done(done2), .tm_stb(stb2), .tm_clk(sclk2), .tm_dio(dio2)
  );

  tm1638_display_ctrl #(.CLK_DIV(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .digits(digits), .dp_mask(dp_mask),
    .leds(leds), .brightness(brightness), .display_on(display_on),
    .busy(busy5), .done(done5), .tm_stb(stb5), .tm_clk(sclk5), .tm_dio(dio5)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_b [19];
  logic [7:0] dec_b [19];
  logic [7:0] ref1  [19] = '{8'h40, 8'hC0, 8'hFC, 8'h00, 8'h60, 8'h00, 8'hDA, 8'h00, 8'hF2, 8'h00,
                             8'h66, 8'h00, 8'hB6, 8'h00, 8'hBE, 8'h00, 8'hE0, 8'h00, 8'h8F};
  string      seg_lit [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                               "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Segment byte from the list of lit segments: a -> bit 7 ... g -> bit 1, dp bit 0.
  function automatic logic [7:0] seg_of(input int n);
    logic [7:0] r;
    int         c;
    r = 8'h00;
    if (n > 9) return 8'h01;
    for (int k = 0; k < seg_lit[n].len(); k++) begin
      c = int'(seg_lit[n][k]) - 97;
      r[7-c] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = x[7-k];
    return r;
  endfunction

  task automatic build_expected();
    int         nib;
    logic [7:0] s;
    exp_b[0] = 8'h40;
    exp_b[1] = 8'hC0;
    for (int i = 0; i < 8; i++) begin
      nib = int'(digits[28-4*i +: 4]);
      s = seg_of(nib);
      if (nib <= 9) s[0] = dp_mask[7-i];
      exp_b[2+2*i] = s;
      exp_b[3+2*i] = {7'b0, leds[7-i]};
    end
    exp_b[18] = display_on ? (8'h88 | {5'b0, brightness}) : 8'h80;
  endtask

  task automatic randomize_inputs();
    digits     = $urandom;
    dp_mask    = 8'($urandom);
    leds       = 8'($urandom);
    brightness = 3'($urandom);
    display_on = 1'($urandom);
  endtask

  task automatic set_start(input bit use5, input logic v);
    if (use5) start5 = v; else start2 = v;
  endtask

  // Starts one frame, decodes it from the pins and checks timing and content against exp_b.
  task automatic run_frame(input string tag, input bit use5, input int d, input bit chaos);
    logic       b, dn, s, c, dd, pc, ps, in_high, hi_dio;
    logic [7:0] sh;
    logic [7:0] raw [19];
    int busy_cnt, done_cnt, done_at, nseg, nbytes, bit_in_byte, seg_start;
    int gap_run, low_run, high_run;
    int viol_low, viol_high, viol_hidio, viol_dio, viol_gap, viol_align, extra_busy;
    int segcnt [3];
    busy_cnt = 0; done_cnt = 0; done_at = -1; nseg = 0; nbytes = 0; bit_in_byte = 0;
    seg_start = 0; gap_run = 0; low_run = 0; high_run = 0;
    viol_low = 0; viol_high = 0; viol_hidio = 0; viol_dio = 0; viol_gap = 0; viol_align = 0;
    extra_busy = 0; segcnt = '{0, 0, 0};
    pc = 1'b1; ps = 1'b1; in_high = 1'b0; hi_dio = 1'b1; sh = '0;
    for (int k = 0; k < 19; k++) raw[k] = '0;

    @(negedge clk);
    set_start(use5, 1'b1);
    @(negedge clk);
    set_start(use5, 1'b0);
    check({tag, "_busy_rise"}, use5 ? busy5 : busy2, 1'b1);

    for (int cyc = 0; cyc < 400 * d; cyc++) begin
      b  = use5 ? busy5 : busy2;
      dn = use5 ? done5 : done2;
      s  = use5 ? stb5  : stb2;
      c  = use5 ? sclk5 : sclk2;
      dd = use5 ? dio5  : dio2;
      if (!b) break;
      busy_cnt++;
      if (dn) begin done_cnt++; done_at = busy_cnt; end
      if (!s && ps) begin
        if (nseg > 0 && gap_run != 2 * d) viol_gap++;
        nseg++;
        seg_start = nbytes;
        if (bit_in_byte != 0) viol_align++;
        bit_in_byte = 0;
      end
      if (s && !ps) begin
        if (nseg >= 1 && nseg <= 3) segcnt[nseg-1] = nbytes - seg_start;
        if (bit_in_byte != 0) viol_align++;
        in_high = 1'b0;
        gap_run = 0;
      end
      if (s) begin
        gap_run++;
        if (dd !== 1'b1) viol_dio++;
      end else begin
        if (!c && pc) begin
          if (in_high && high_run != d) viol_high++;
          in_high = 1'b0;
          low_run = 0;
        end
        if (c && !pc) begin
          if (low_run != d) viol_low++;
          sh[bit_in_byte] = dd;
          bit_in_byte++;
          if (bit_in_byte == 8) begin
            if (nbytes < 19) raw[nbytes] = sh;
            nbytes++;
            bit_in_byte = 0;
          end
          in_high = 1'b1;
          high_run = 0;
          hi_dio = dd;
        end
        if (!c) low_run++;
        if (c && in_high) begin
          high_run++;
          if (high_run <= d && dd !== hi_dio) viol_hidio++;
        end
      end
      if (chaos) begin
        set_start(use5, dn ? 1'b0 : 1'($urandom));
        randomize_inputs();
      end
      pc = c;
      ps = s;
      @(negedge clk);
    end
    set_start(use5, 1'b0);
    repeat (8) begin
      if (use5 ? busy5 : busy2) extra_busy++;
      @(negedge clk);
    end

    check({tag, "_busy_cycles"}, busy_cnt, 316 * d);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_last"}, done_at, busy_cnt);
    check({tag, "_no_refire"}, extra_busy, 0);
    check({tag, "_segments"}, nseg, 3);
    check({tag, "_seg_bytes"}, {segcnt[0][7:0], segcnt[1][7:0], segcnt[2][7:0]}, 24'h011101);
    check({tag, "_final_gap"}, gap_run, 2 * d);
    check({tag, "_timing"}, {viol_low[7:0], viol_high[7:0], viol_gap[7:0], viol_align[7:0]}, 32'h0);
    check({tag, "_dio_idle_hold"}, {viol_dio[15:0], viol_hidio[15:0]}, 32'h0);
    check({tag, "_nbytes"}, nbytes, 19);
    for (int k = 0; k < 19; k++) begin
      dec_b[k] = (k >= 2 && k <= 16 && k % 2 == 0) ? rev8(raw[k]) : raw[k];
      check($sformatf("%s_byte%0d", tag, k), dec_b[k], exp_b[k]);
    end
  endtask

  initial begin
    int         rst_busy;
    int         rst_done;
    logic [7:0] led_exp [8];

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_stb2", stb2, 1'b1);
    check("rst_clk2", sclk2, 1'b1);
    check("rst_dio2", dio2, 1'b1);
    check("rst_busy2", busy2, 1'b0);
    check("rst_done2", done2, 1'b0);
    check("rst_pins5", {stb5, sclk5, dio5, busy5, done5}, 5'b11100);

    // Digits 0..7, all points and LEDs off, full brightness.
    digits = 32'h0123_4567; dp_mask = 8'h00; leds = 8'h00; brightness = 3'd7; display_on = 1'b1;
    exp_b = ref1;
    run_frame("f1", 1'b0, 2, 1'b0);

    // Error nibbles, decimal point, LED pattern, display off.
    digits = 32'hF9AB_0000; dp_mask = 8'h80; leds = 8'hA5; brightness = 3'd3; display_on = 1'b0;
    build_expected();
    run_frame("f2", 1'b0, 2, 1'b0);
    check("f2_d0", dec_b[2], 8'h01);
    check("f2_d1", dec_b[4], 8'hF6);
    check("f2_d2", dec_b[6], 8'h01);
    check("f2_d3", dec_b[8], 8'h01);
    led_exp = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01};
    for (int i = 0; i < 8; i++) check($sformatf("f2_led%0d", i), dec_b[3+2*i], led_exp[i]);
    check("f2_cmd3", dec_b[18], 8'h80);

    // Repeated start and changing inputs while busy: one frame with snapshot data.
    randomize_inputs();
    build_expected();
    run_frame("chaos", 1'b0, 2, 1'b1);

    // Reset in the middle of segment 2.
    randomize_inputs();
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_busy", busy2, 1'b1);
    check("mid_stb_low", stb2, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_pins", {stb2, sclk2, dio2}, 3'b111);
    check("abort_busy", busy2, 1'b0);
    check("abort_done", done2, 1'b0);
    rst_busy = 0;
    rst_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy2) rst_busy++;
      if (done2) rst_done++;
    end
    check("abort_quiet", {rst_busy[15:0], rst_done[15:0]}, 32'h0);

    randomize_inputs();
    build_expected();
    run_frame("post_rst", 1'b0, 2, 1'b0);

    // Slower divider for phase-length and gap timing.
    randomize_inputs();
    build_expected();
    run_frame("div5", 1'b1, 5, 1'b0);

    for (int r = 0; r < 2; r++) begin
      randomize_inputs();
      build_expected();
      run_frame($sformatf("rnd%0d", r), 1'b0, 2, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
